// File: rtl/ttt_game_ctrl_if.sv
// Button-pulse inputs and board/status outputs of the tic-tac-toe game controller.
// The controller uses the slave modport; whoever presses the buttons uses master.
interface ttt_game_ctrl_if;
  logic        BTN_UP;
  logic        BTN_DOWN;
  logic        BTN_LEFT;
  logic        BTN_RIGHT;
  logic        BTN_SELECT;
  logic [35:0] CONTROL_ARRAY;
  logic [1:0]  GAME_STATE;
  logic [1:0]  WINNER;
  logic        TURN;
  logic [3:0]  MOVE_COUNT;

  modport master (
    output BTN_UP, BTN_DOWN, BTN_LEFT, BTN_RIGHT, BTN_SELECT,
    input  CONTROL_ARRAY, GAME_STATE, WINNER, TURN, MOVE_COUNT
  );

  modport slave (
    input  BTN_UP, BTN_DOWN, BTN_LEFT, BTN_RIGHT, BTN_SELECT,
    output CONTROL_ARRAY, GAME_STATE, WINNER, TURN, MOVE_COUNT
  );
endinterface

// File: rtl/ttt_game_ctrl.sv
// Tic-tac-toe game-state controller: board, cursor, turn, win/draw detection
// and the registered per-cell display codes for the VGA block.
module ttt_game_ctrl #(
  parameter int BLINK_DIV = 20000000
) (
  input logic            CLK,
  input logic            RESET,
  ttt_game_ctrl_if.slave bus
);

  typedef enum logic [1:0] {PLAY = 2'd0, CHECK = 2'd1, WIN = 2'd2, DRAW = 2'd3} state_e;

  localparam int            CW         = $clog2(BLINK_DIV);
  localparam logic [CW-1:0] BLINK_LAST = CW'(BLINK_DIV - 1);
  localparam logic [35:0]   CTRL_RESET = 36'h000010000;
  // Cell-index masks of the three rows, three columns and two diagonals.
  localparam logic [8:0] LINE_MASK [8] = '{
    9'b000000111, 9'b000111000, 9'b111000000,
    9'b001001001, 9'b010010010, 9'b100100100,
    9'b100010001, 9'b001010100
  };

  state_e          state_q;
  logic [8:0][1:0] board_q;
  logic [3:0]      cursor_q;
  logic [3:0]      moves_q;
  logic            turn_q;
  logic [1:0]      winner_q;
  logic [8:0]      winMask_q;
  logic [CW-1:0]   blinkCnt_q;
  logic            blinkVis_q;
  logic [35:0]     ctrl_q;

  logic [1:0]  player;
  logic [8:0]  mine;
  logic [8:0]  winMask_d;
  logic [35:0] ctrl_d;
  logic [1:0]  overlay;
  logic [3:0]  cursorUp_d, cursorDown_d, cursorLeft_d, cursorRight_d;
  logic        colZero, colTwo, cellFree, moveReq, blinkRestart;

  always_comb begin
    player    = turn_q ? 2'd2 : 2'd1;
    mine      = '0;
    winMask_d = '0;
    for (int c = 0; c < 9; c++) mine[c] = (board_q[c] == player);
    for (int l = 0; l < 8; l++)
      if ((mine & LINE_MASK[l]) == LINE_MASK[l]) winMask_d = winMask_d | LINE_MASK[l];

    colZero       = (cursor_q == 4'd0) || (cursor_q == 4'd3) || (cursor_q == 4'd6);
    colTwo        = (cursor_q == 4'd2) || (cursor_q == 4'd5) || (cursor_q == 4'd8);
    cursorUp_d    = (cursor_q < 4'd3) ? cursor_q + 4'd6 : cursor_q - 4'd3;
    cursorDown_d  = (cursor_q > 4'd5) ? cursor_q - 4'd6 : cursor_q + 4'd3;
    cursorLeft_d  = colZero ? cursor_q + 4'd2 : cursor_q - 4'd1;
    cursorRight_d = colTwo ? cursor_q - 4'd2 : cursor_q + 4'd1;

    cellFree     = (board_q[cursor_q] == 2'd0);
    moveReq      = bus.BTN_UP | bus.BTN_DOWN | bus.BTN_LEFT | bus.BTN_RIGHT;
    // Any accepted cursor move, placement or restart makes the cursor visible at once.
    blinkRestart = ((state_q == PLAY) && (bus.BTN_SELECT ? cellFree : moveReq)) ||
                   (((state_q == WIN) || (state_q == DRAW)) && bus.BTN_SELECT);

    ctrl_d  = '0;
    overlay = 2'd0;
    for (int c = 0; c < 9; c++) begin
      overlay = 2'd0;
      if ((state_q == PLAY) && blinkVis_q && (cursor_q == 4'(c)))
        overlay = player;
      else if ((state_q == WIN) && blinkVis_q && winMask_q[c])
        overlay = winner_q;
      ctrl_d[c*4 +: 4] = {2'b00, board_q[c]} * 4'd3 + {2'b00, overlay};
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q    <= PLAY;
      board_q    <= '0;
      cursor_q   <= 4'd4;
      moves_q    <= 4'd0;
      turn_q     <= 1'b0;
      winner_q   <= 2'd0;
      winMask_q  <= '0;
      blinkCnt_q <= '0;
      blinkVis_q <= 1'b1;
      ctrl_q     <= CTRL_RESET;
    end else begin
      ctrl_q <= ctrl_d;

      if (blinkRestart) begin
        blinkCnt_q <= '0;
        blinkVis_q <= 1'b1;
      end else if (blinkCnt_q == BLINK_LAST) begin
        blinkCnt_q <= '0;
        blinkVis_q <= ~blinkVis_q;
      end else begin
        blinkCnt_q <= blinkCnt_q + CW'(1);
      end

      case (state_q)
        PLAY: begin
          if (bus.BTN_SELECT) begin
            if (cellFree) begin
              board_q[cursor_q] <= player;
              moves_q           <= moves_q + 4'd1;
              state_q           <= CHECK;
            end
          end else if (bus.BTN_UP)    cursor_q <= cursorUp_d;
          else if (bus.BTN_DOWN)      cursor_q <= cursorDown_d;
          else if (bus.BTN_LEFT)      cursor_q <= cursorLeft_d;
          else if (bus.BTN_RIGHT)     cursor_q <= cursorRight_d;
        end
        CHECK: begin
          if (winMask_d != 9'd0) begin
            state_q   <= WIN;
            winner_q  <= player;
            winMask_q <= winMask_d;
          end else if (moves_q == 4'd9) begin
            state_q <= DRAW;
          end else begin
            turn_q  <= ~turn_q;
            state_q <= PLAY;
          end
        end
        default: begin
          if (bus.BTN_SELECT) begin
            state_q   <= PLAY;
            board_q   <= '0;
            cursor_q  <= 4'd4;
            moves_q   <= 4'd0;
            turn_q    <= 1'b0;
            winner_q  <= 2'd0;
            winMask_q <= '0;
          end
        end
      endcase
    end
  end

  assign bus.CONTROL_ARRAY = ctrl_q;
  assign bus.GAME_STATE    = state_q;
  assign bus.WINNER        = winner_q;
  assign bus.TURN          = turn_q;
  assign bus.MOVE_COUNT    = moves_q;

endmodule

// File: tb/tb_ttt_game_ctrl.sv
// Testbench for ttt_game_ctrl: directed scenarios plus random button traffic,
// all compared against a game-level reference model of the controller.
module tb_ttt_game_ctrl;
  localparam int BLINK_DIV = 4;
  localparam logic [35:0] CTRL_RESET = 36'h000010000;

  logic CLK = 1'b0;
  logic RESET = 1'b1;
  int checks = 0;
  int errors = 0;

  ttt_game_ctrl_if bus ();

  ttt_game_ctrl #(.BLINK_DIV(BLINK_DIV)) dut (
    .CLK  (CLK),
    .RESET(RESET),
    .bus  (bus)
  );

  always #5 CLK = ~CLK;

  // Reference model: game kept as plain integers (0=PLAY 1=CHECK 2=WIN 3=DRAW)
  int mBoard [9];
  int mRow, mCol, mTurn, mState, mWinner, mMoves, mBlinkCnt;
  bit mVis;
  logic [35:0] mCtrl;
  int winLines [8][3] = '{'{0,1,2}, '{3,4,5}, '{6,7,8}, '{0,3,6},
                          '{1,4,7}, '{2,5,8}, '{0,4,8}, '{2,4,6}};

  task automatic modelReset();
    foreach (mBoard[c]) mBoard[c] = 0;
    mRow = 1; mCol = 1; mTurn = 0; mState = 0; mWinner = 0; mMoves = 0;
    mBlinkCnt = 0; mVis = 1'b1;
  endtask

  function automatic bit lineDone(int l, int p);
    return mBoard[winLines[l][0]] == p && mBoard[winLines[l][1]] == p && mBoard[winLines[l][2]] == p;
  endfunction

  function automatic bit cellInWin(int c, int p);
    for (int l = 0; l < 8; l++)
      if (lineDone(l, p) && (winLines[l][0] == c || winLines[l][1] == c || winLines[l][2] == c))
        return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [35:0] modelDisplay();
    logic [35:0] r = '0;
    for (int c = 0; c < 9; c++) begin
      int ovl = 0;
      if (mState == 0 && mVis && c == mRow * 3 + mCol) ovl = mTurn + 1;
      else if (mState == 2 && mVis && cellInWin(c, mWinner)) ovl = mWinner;
      r[c*4 +: 4] = 4'(mBoard[c] * 3 + ovl);
    end
    return r;
  endfunction

  function automatic logic [8:0] modelStatus();
    return {2'(mState), 2'(mWinner), 1'(mTurn), 4'(mMoves)};
  endfunction

  task automatic modelStep(input bit rst, up, dn, lf, rt, sel);
    bit restartBlink = 1'b0;
    if (rst) begin
      modelReset();
      mCtrl = CTRL_RESET;
      return;
    end
    mCtrl = modelDisplay();
    case (mState)
      0: begin
        if (sel) begin
          if (mBoard[mRow * 3 + mCol] == 0) begin
            mBoard[mRow * 3 + mCol] = mTurn + 1;
            mMoves++;
            mState = 1;
            restartBlink = 1'b1;
          end
        end else if (up) begin mRow = (mRow + 2) % 3; restartBlink = 1'b1; end
        else if (dn)     begin mRow = (mRow + 1) % 3; restartBlink = 1'b1; end
        else if (lf)     begin mCol = (mCol + 2) % 3; restartBlink = 1'b1; end
        else if (rt)     begin mCol = (mCol + 1) % 3; restartBlink = 1'b1; end
      end
      1: begin
        bit won = 1'b0;
        for (int l = 0; l < 8; l++) if (lineDone(l, mTurn + 1)) won = 1'b1;
        if (won) begin mState = 2; mWinner = mTurn + 1; end
        else if (mMoves == 9) mState = 3;
        else begin mTurn = 1 - mTurn; mState = 0; end
      end
      default: if (sel) begin modelReset(); restartBlink = 1'b1; end
    endcase
    if (restartBlink) begin
      mBlinkCnt = 0; mVis = 1'b1;
    end else if (mBlinkCnt == BLINK_DIV - 1) begin
      mBlinkCnt = 0; mVis = !mVis;
    end else begin
      mBlinkCnt++;
    end
  endtask

  // One clock: drive pulses, advance the model at the edge, release just after it.
  task automatic step(input bit rst, up, dn, lf, rt, sel);
    RESET = rst;
    bus.BTN_UP = up; bus.BTN_DOWN = dn; bus.BTN_LEFT = lf; bus.BTN_RIGHT = rt; bus.BTN_SELECT = sel;
    @(posedge CLK);
    modelStep(rst, up, dn, lf, rt, sel);
    #1;
    RESET = 1'b0;
    bus.BTN_UP = 0; bus.BTN_DOWN = 0; bus.BTN_LEFT = 0; bus.BTN_RIGHT = 0; bus.BTN_SELECT = 0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0);
  endtask

  task automatic placeAt(input int idx);
    int guard = 0;
    while ((mRow != idx / 3 || mCol != idx % 3) && guard < 10) begin
      if (mRow != idx / 3) step(0, 0, 1, 0, 0, 0);
      else step(0, 0, 0, 0, 1, 0);
      guard++;
    end
    step(0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_reset();
    step(1, 0, 0, 0, 0, 0);
    idle(2);
    checks++;
    if (bus.CONTROL_ARRAY !== CTRL_RESET) begin
      errors++; $display("[TB] FAIL reset_ctrl: got %h expected %h", bus.CONTROL_ARRAY, CTRL_RESET);
    end
    checks++;
    if ({bus.GAME_STATE, bus.WINNER, bus.TURN, bus.MOVE_COUNT} !== 9'd0) begin
      errors++; $display("[TB] FAIL reset_status: state=%0d winner=%0d turn=%0d moves=%0d expected all 0",
                         bus.GAME_STATE, bus.WINNER, bus.TURN, bus.MOVE_COUNT);
    end
  endtask

  task automatic test_cursor();
    logic [35:0] expCtrl [3] = '{36'h000000010, 36'h000000001, 36'h000000100};
    for (int k = 0; k < 3; k++) begin
      if (k == 0) step(0, 1, 0, 0, 0, 0);
      else step(0, 0, 0, 1, 0, 0);
      idle(1);
      checks++;
      if (bus.CONTROL_ARRAY !== expCtrl[k] || mCtrl !== expCtrl[k]) begin
        errors++; $display("[TB] FAIL cursor_move%0d: got %h expected %h", k, bus.CONTROL_ARRAY, expCtrl[k]);
      end
    end
  endtask

  task automatic test_place();
    step(1, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1);
    checks++;
    if (bus.GAME_STATE !== 2'd1) begin
      errors++; $display("[TB] FAIL place_check_state: got %0d expected 1", bus.GAME_STATE);
    end
    idle(1);
    checks++;
    if ({bus.GAME_STATE, bus.TURN, bus.MOVE_COUNT} !== {2'd0, 1'b1, 4'd1}) begin
      errors++; $display("[TB] FAIL place_status: state=%0d turn=%0d moves=%0d expected 0/1/1",
                         bus.GAME_STATE, bus.TURN, bus.MOVE_COUNT);
    end
    idle(1);
    checks++;
    if (bus.CONTROL_ARRAY !== 36'h000050000) begin
      errors++; $display("[TB] FAIL place_ctrl: got %h expected %h", bus.CONTROL_ARRAY, 36'h000050000);
    end
    step(0, 0, 0, 0, 0, 1);
    idle(1);
    checks++;
    if ({bus.GAME_STATE, bus.TURN, bus.MOVE_COUNT} !== {2'd0, 1'b1, 4'd1} ||
        bus.CONTROL_ARRAY !== 36'h000050000) begin
      errors++; $display("[TB] FAIL occupied_select: state=%0d moves=%0d ctrl=%h expected 0/1/%h",
                         bus.GAME_STATE, bus.MOVE_COUNT, bus.CONTROL_ARRAY, 36'h000050000);
    end
  endtask

  task automatic test_win();
    int order [5] = '{0, 3, 1, 4, 2};
    bit seenOn = 0, seenOff = 0;
    step(1, 0, 0, 0, 0, 0);
    foreach (order[k]) placeAt(order[k]);
    checks++;
    if (bus.GAME_STATE !== 2'd2 || bus.WINNER !== 2'd1) begin
      errors++; $display("[TB] FAIL win_status: state=%0d winner=%0d expected 2/1", bus.GAME_STATE, bus.WINNER);
    end
    for (int i = 0; i < 12; i++) begin
      idle(1);
      checks++;
      if (bus.CONTROL_ARRAY !== mCtrl) begin
        errors++; $display("[TB] FAIL win_blink%0d: got %h expected %h", i, bus.CONTROL_ARRAY, mCtrl);
      end
      checks++;
      if (bus.CONTROL_ARRAY[11:0] === 12'h444) seenOn = 1;
      else if (bus.CONTROL_ARRAY[11:0] === 12'h333) seenOff = 1;
      else begin
        errors++; $display("[TB] FAIL win_cells: got %h expected 444 or 333", bus.CONTROL_ARRAY[11:0]);
      end
    end
    checks++;
    if (!(seenOn && seenOff)) begin
      errors++; $display("[TB] FAIL win_toggle: on=%0d off=%0d expected both 1", seenOn, seenOff);
    end
    step(0, 0, 0, 0, 0, 1);
    idle(1);
    checks++;
    if (bus.CONTROL_ARRAY !== CTRL_RESET || {bus.GAME_STATE, bus.WINNER, bus.TURN, bus.MOVE_COUNT} !== 9'd0) begin
      errors++; $display("[TB] FAIL win_restart: ctrl=%h state=%0d moves=%0d expected %h/0/0",
                         bus.CONTROL_ARRAY, bus.GAME_STATE, bus.MOVE_COUNT, CTRL_RESET);
    end
  endtask

  task automatic test_draw();
    int order [9] = '{0, 1, 2, 4, 3, 5, 7, 6, 8};
    step(1, 0, 0, 0, 0, 0);
    foreach (order[k]) placeAt(order[k]);
    idle(1);
    checks++;
    if (bus.GAME_STATE !== 2'd3 || bus.WINNER !== 2'd0 || bus.MOVE_COUNT !== 4'd9) begin
      errors++; $display("[TB] FAIL draw_status: state=%0d winner=%0d moves=%0d expected 3/0/9",
                         bus.GAME_STATE, bus.WINNER, bus.MOVE_COUNT);
    end
    checks++;
    if (bus.CONTROL_ARRAY !== 36'h336663363) begin
      errors++; $display("[TB] FAIL draw_ctrl: got %h expected %h", bus.CONTROL_ARRAY, 36'h336663363);
    end
    step(0, 1, 0, 0, 0, 0);
    idle(1);
    checks++;
    if (bus.GAME_STATE !== 2'd3 || bus.CONTROL_ARRAY !== 36'h336663363) begin
      errors++; $display("[TB] FAIL draw_up_ignored: state=%0d ctrl=%h expected 3/%h",
                         bus.GAME_STATE, bus.CONTROL_ARRAY, 36'h336663363);
    end
  endtask

  task automatic test_priority();
    step(1, 0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 1);
    checks++;
    if (bus.GAME_STATE !== 2'd1 || bus.MOVE_COUNT !== 4'd1) begin
      errors++; $display("[TB] FAIL up_select_place: state=%0d moves=%0d expected 1/1", bus.GAME_STATE, bus.MOVE_COUNT);
    end
    idle(2);
    checks++;
    if (bus.CONTROL_ARRAY !== 36'h000050000) begin
      errors++; $display("[TB] FAIL up_select_cursor: got %h expected %h", bus.CONTROL_ARRAY, 36'h000050000);
    end
    step(0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0, 1);
    step(1, 0, 0, 0, 0, 0);
    checks++;
    if (bus.CONTROL_ARRAY !== CTRL_RESET || {bus.GAME_STATE, bus.WINNER, bus.TURN, bus.MOVE_COUNT} !== 9'd0) begin
      errors++; $display("[TB] FAIL reset_in_check: ctrl=%h state=%0d moves=%0d expected %h/0/0",
                         bus.CONTROL_ARRAY, bus.GAME_STATE, bus.MOVE_COUNT, CTRL_RESET);
    end
  endtask

  task automatic test_random();
    step(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3000; i++) begin
      int r = $urandom_range(0, 15);
      bit [4:0] b = 5'd0;
      if (r < 4) b[r] = 1'b1;
      else if (r < 7) b[4] = 1'b1;
      else if (r == 7) b = 5'($urandom);
      step($urandom_range(0, 299) == 0, b[0], b[1], b[2], b[3], b[4]);
      checks++;
      if (bus.CONTROL_ARRAY !== mCtrl) begin
        errors++; $display("[TB] FAIL random_ctrl@%0d: got %h expected %h", i, bus.CONTROL_ARRAY, mCtrl);
      end
      checks++;
      if ({bus.GAME_STATE, bus.WINNER, bus.TURN, bus.MOVE_COUNT} !== modelStatus()) begin
        errors++; $display("[TB] FAIL random_status@%0d: got %b expected %b", i,
                           {bus.GAME_STATE, bus.WINNER, bus.TURN, bus.MOVE_COUNT}, modelStatus());
      end
    end
  endtask

  initial begin
    bus.BTN_UP = 0; bus.BTN_DOWN = 0; bus.BTN_LEFT = 0; bus.BTN_RIGHT = 0; bus.BTN_SELECT = 0;
    modelReset();
    mCtrl = CTRL_RESET;
    test_reset();
    test_cursor();
    test_place();
    test_win();
    test_draw();
    test_priority();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
